// File: rtl/memory_types_pkg.sv
// Shared memory-port packet and opcode types, plus the requester-ID type the
// arbiter uses to remember who issued each outstanding request.
package memory_types_pkg;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_RMW   = 2'd2,
    MEM_NOP   = 2'd3
  } mem_op_e;

  typedef struct packed {
    mem_op_e             mtype;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
    logic [DATA_W-1:0]   data;
  } mem_pkt_t;

  typedef logic req_id_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Small synchronous FIFO holding the requester ID of every request that the
// memory has accepted but not yet answered.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rdPtr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap explicitly so the FIFO stays correct for any depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter onto one in-order memory port,
// routing responses back by a FIFO of issuing requester IDs.
module mem_port_arbiter
  import memory_types_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     m0_req_vld,
  output logic     m0_req_rdy,
  input  mem_pkt_t m0_req,
  output logic     m0_rsp_vld,
  input  logic     m0_rsp_rdy,
  output mem_pkt_t m0_rsp,
  input  logic     m1_req_vld,
  output logic     m1_req_rdy,
  input  mem_pkt_t m1_req,
  output logic     m1_rsp_vld,
  input  logic     m1_rsp_rdy,
  output mem_pkt_t m1_rsp,
  output logic     mem_req_vld,
  input  logic     mem_req_rdy,
  output mem_pkt_t mem_req,
  input  logic     mem_rsp_vld,
  output logic     mem_rsp_rdy,
  input  mem_pkt_t mem_rsp,
  output logic     err_unexp_rsp
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_e;

  state_e  r_state;
  state_e  w_nextState;
  logic    r_rr;
  logic    r_err;
  req_id_t w_grant;
  req_id_t w_head;
  logic    w_selVld;
  logic    w_grantRdy;
  logic    w_handshake;
  logic    w_pop;
  logic    w_full;
  logic    w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_rr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_handshake) begin
        r_rr <= ~w_grant;
      end
      if (mem_rsp_vld && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Handshake strobes are qualified with rst_n so all outputs drop the moment reset asserts.
  always_comb begin
    w_grant     = 1'b0;
    w_nextState = ARB;
    case (r_state)
      ARB: begin
        if (m0_req_vld && m1_req_vld) begin
          w_grant = r_rr;
        end else if (m1_req_vld) begin
          w_grant = 1'b1;
        end
      end
      HOLD0:   w_grant = 1'b0;
      HOLD1:   w_grant = 1'b1;
      default: w_grant = 1'b0;
    endcase

    w_selVld    = w_grant ? m1_req_vld : m0_req_vld;
    mem_req     = w_grant ? m1_req : m0_req;
    mem_req_vld = rst_n && w_selVld && !w_full;
    w_grantRdy  = rst_n && mem_req_rdy && !w_full;
    m0_req_rdy  = !w_grant && w_grantRdy;
    m1_req_rdy  = w_grant && w_grantRdy;
    w_handshake = mem_req_vld && mem_req_rdy;

    if (w_handshake) begin
      w_nextState = ARB;
    end else if (w_selVld) begin
      w_nextState = w_grant ? HOLD1 : HOLD0;
    end else begin
      w_nextState = ARB;
    end
  end

  // Responses are in request order, so the FIFO head names their owner.
  always_comb begin
    m0_rsp      = mem_rsp;
    m1_rsp      = mem_rsp;
    m0_rsp_vld  = rst_n && mem_rsp_vld && !w_empty && !w_head;
    m1_rsp_vld  = rst_n && mem_rsp_vld && !w_empty && w_head;
    mem_rsp_rdy = rst_n && (w_empty || (w_head ? m1_rsp_rdy : m0_rsp_rdy));
    w_pop       = mem_rsp_vld && mem_rsp_rdy && !w_empty;
  end

  assign err_unexp_rsp = r_err;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(req_id_t))
  ) u_idFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_handshake),
    .i_pop   (w_pop),
    .i_data  (w_grant),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, stalls, FIFO-full blocking,
// response routing/backpressure, unexpected-response flag and async reset.
module tb_mem_port_arbiter;
  import memory_types_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     m0_req_vld, m0_req_rdy, m0_rsp_vld, m0_rsp_rdy;
  logic     m1_req_vld, m1_req_rdy, m1_rsp_vld, m1_rsp_rdy;
  logic     mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
  logic     err_unexp_rsp;
  mem_pkt_t m0_req, m1_req, m0_rsp, m1_rsp, mem_req, mem_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTST(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_req_vld    (m0_req_vld),
    .m0_req_rdy    (m0_req_rdy),
    .m0_req        (m0_req),
    .m0_rsp_vld    (m0_rsp_vld),
    .m0_rsp_rdy    (m0_rsp_rdy),
    .m0_rsp        (m0_rsp),
    .m1_req_vld    (m1_req_vld),
    .m1_req_rdy    (m1_req_rdy),
    .m1_req        (m1_req),
    .m1_rsp_vld    (m1_rsp_vld),
    .m1_rsp_rdy    (m1_rsp_rdy),
    .m1_rsp        (m1_rsp),
    .mem_req_vld   (mem_req_vld),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req       (mem_req),
    .mem_rsp_vld   (mem_rsp_vld),
    .mem_rsp_rdy   (mem_rsp_rdy),
    .mem_rsp       (mem_rsp),
    .err_unexp_rsp (err_unexp_rsp)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic mrdy,
                               input logic rvld, input logic r0, input logic r1);
    m0_req_vld  = v0;
    m1_req_vld  = v1;
    mem_req_rdy = mrdy;
    mem_rsp_vld = rvld;
    m0_rsp_rdy  = r0;
    m1_rsp_rdy  = r1;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    m0_req  = '{mtype: MEM_READ,  addr: 32'h100, len: 8'd4, data: 32'h0};
    m1_req  = '{mtype: MEM_WRITE, addr: 32'h200, len: 8'd1, data: 32'hDEAD};
    mem_rsp = '{mtype: MEM_READ,  addr: 32'h0,   len: 8'd0, data: 32'hAA};

    // Reset asserted with everything active on the inputs
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("rst_mem_req_vld", 32'(mem_req_vld), 32'd0);
    checkOutput("rst_m0_req_rdy", 32'(m0_req_rdy), 32'd0);
    checkOutput("rst_m1_req_rdy", 32'(m1_req_rdy), 32'd0);
    checkOutput("rst_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("rst_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    stepClock();
    stepClock();
    checkOutput("rst_err", 32'(err_unexp_rsp), 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 1);
    stepClock();

    // Both requesting, memory always ready, immediate responses: grants alternate
    $display("[TB] alternating grants");
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("alt0_vld", 32'(mem_req_vld), 32'd1);
    checkOutput("alt0_addr", mem_req.addr, 32'h100);
    checkOutput("alt0_m0_rdy", 32'(m0_req_rdy), 32'd1);
    checkOutput("alt0_m1_rdy", 32'(m1_req_rdy), 32'd0);
    stepClock();
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("alt1_addr", mem_req.addr, 32'h200);
    checkOutput("alt1_m1_rdy", 32'(m1_req_rdy), 32'd1);
    checkOutput("alt1_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
    checkOutput("alt1_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    checkOutput("alt1_m0_rsp_data", m0_rsp.data, 32'hAA);
    stepClock();
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("alt2_addr", mem_req.addr, 32'h100);
    checkOutput("alt2_m1_rsp_vld", 32'(m1_rsp_vld), 32'd1);
    checkOutput("alt2_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("alt2_m1_rsp_data", m1_rsp.data, 32'hAA);
    stepClock();
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("alt3_addr", mem_req.addr, 32'h200);
    checkOutput("alt3_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
    stepClock();
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("drain_mem_req_vld", 32'(mem_req_vld), 32'd0);
    checkOutput("drain_m1_rsp_vld", 32'(m1_rsp_vld), 32'd1);
    stepClock();

    // Memory stall on m0 for 3 cycles while m1 also waits
    $display("[TB] stall hold");
    applyStimulus(1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_vld", 32'(mem_req_vld), 32'd1);
      checkOutput("stall_addr", mem_req.addr, 32'h100);
      checkOutput("stall_m0_rdy", 32'(m0_req_rdy), 32'd0);
      stepClock();
    end
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("stall_acc_addr", mem_req.addr, 32'h100);
    checkOutput("stall_acc_m0_rdy", 32'(m0_req_rdy), 32'd1);
    checkOutput("stall_acc_m1_rdy", 32'(m1_req_rdy), 32'd0);
    stepClock();
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("after_stall_addr", mem_req.addr, 32'h200);
    checkOutput("after_stall_m1_rdy", 32'(m1_req_rdy), 32'd1);
    stepClock();

    // HOLD1 ignores m0, then m1 drops valid: back to ARB with no push
    $display("[TB] hold1 and dropped valid");
    applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("h1_addr", mem_req.addr, 32'h200);
    stepClock();
    applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("h1_drop_vld", 32'(mem_req_vld), 32'd0);
    checkOutput("h1_drop_m0_rdy", 32'(m0_req_rdy), 32'd0);
    checkOutput("h1_drop_m1_rdy", 32'(m1_req_rdy), 32'd1);
    stepClock();
    applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("h1_arb_addr", mem_req.addr, 32'h100);
    checkOutput("h1_arb_m0_rdy", 32'(m0_req_rdy), 32'd1);
    stepClock();

    // Fill to MAX_OUTST, then a pop only unblocks on the following cycle
    $display("[TB] full");
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("fill4_addr", mem_req.addr, 32'h200);
    stepClock();
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("full_vld", 32'(mem_req_vld), 32'd0);
    checkOutput("full_m0_rdy", 32'(m0_req_rdy), 32'd0);
    checkOutput("full_m1_rdy", 32'(m1_req_rdy), 32'd0);
    checkOutput("full_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
    checkOutput("full_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
    stepClock();
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("unfull_vld", 32'(mem_req_vld), 32'd1);
    checkOutput("unfull_addr", mem_req.addr, 32'h100);
    checkOutput("unfull_m0_rdy", 32'(m0_req_rdy), 32'd1);
    stepClock();

    // Outstanding IDs are 1,0,1,0; m1 stalls its response for 2 cycles
    $display("[TB] response backpressure");
    mem_rsp.data = 32'h11;
    applyStimulus(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_m1_rsp_vld", 32'(m1_rsp_vld), 32'd1);
      checkOutput("bp_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
      checkOutput("bp_rsp_rdy", 32'(mem_rsp_rdy), 32'd0);
      stepClock();
    end
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("bp_rel_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
    checkOutput("bp_rel_m1_rsp_vld", 32'(m1_rsp_vld), 32'd1);
    checkOutput("bp_rel_m1_data", m1_rsp.data, 32'h11);
    stepClock();
    checkOutput("ord0_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
    checkOutput("ord0_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    stepClock();
    checkOutput("ord1_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("ord1_m1_rsp_vld", 32'(m1_rsp_vld), 32'd1);
    stepClock();
    checkOutput("ord2_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
    checkOutput("ord2_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    stepClock();

    // Unexpected response with the FIFO empty
    $display("[TB] unexpected response");
    checkOutput("unexp_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("unexp_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    checkOutput("unexp_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
    checkOutput("unexp_err_before", 32'(err_unexp_rsp), 32'd0);
    stepClock();
    checkOutput("unexp_err_set", 32'(err_unexp_rsp), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    stepClock();
    checkOutput("unexp_err_sticky", 32'(err_unexp_rsp), 32'd1);

    // Two outstanding plus a stalled request, then async reset mid-cycle
    $display("[TB] reset mid-transaction");
    applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("pre_rst_m0_rdy", 32'(m0_req_rdy), 32'd1);
    stepClock();
    applyStimulus(0, 1, 1, 0, 1, 1);
    checkOutput("pre_rst_m1_rdy", 32'(m1_req_rdy), 32'd1);
    stepClock();
    applyStimulus(1, 1, 0, 0, 1, 1);
    checkOutput("pre_rst_stall_vld", 32'(mem_req_vld), 32'd1);
    stepClock();
    rst_n = 1'b0;
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("mid_rst_mem_req_vld", 32'(mem_req_vld), 32'd0);
    checkOutput("mid_rst_m0_req_rdy", 32'(m0_req_rdy), 32'd0);
    checkOutput("mid_rst_m1_req_rdy", 32'(m1_req_rdy), 32'd0);
    checkOutput("mid_rst_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("mid_rst_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    checkOutput("mid_rst_rsp_rdy", 32'(mem_rsp_rdy), 32'd0);
    checkOutput("mid_rst_err", 32'(err_unexp_rsp), 32'd0);
    stepClock();
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("post_rst_m0_rsp_vld", 32'(m0_rsp_vld), 32'd0);
    checkOutput("post_rst_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
    checkOutput("post_rst_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
    stepClock();
    checkOutput("post_rst_err", 32'(err_unexp_rsp), 32'd1);
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("post_rst_rr_addr", mem_req.addr, 32'h100);
    checkOutput("post_rst_rr_m0_rdy", 32'(m0_req_rdy), 32'd1);
    stepClock();
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("post_rst_route_m0", 32'(m0_rsp_vld), 32'd1);
    checkOutput("post_rst_route_m1", 32'(m1_rsp_vld), 32'd0);
    stepClock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning maximum requests accepted downstream but not yet answered (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port mN_req_vld  input  1  requester N (N=0 fetch, N=1 data) request valid.
REQ-005 SHALL have port mN_req_rdy  output  1  requester N request accepted this cycle when high with mN_req_vld.
REQ-006 SHALL have port mN_req  input  mem_pkt_t  requester N packet (mtype, addr, len, data).
REQ-007 SHALL have port mN_rsp_vld  output  1  response valid to requester N.
REQ-008 SHALL have port mN_rsp_rdy  input  1  requester N accepts response.
REQ-009 SHALL have port mN_rsp  output  mem_pkt_t  response packet to requester N.
REQ-010 SHALL have port mem_req_vld  output  1  shared memory request valid.
REQ-011 SHALL have port mem_req_rdy  input  1  shared memory accepts request.
REQ-012 SHALL have port mem_req  output  mem_pkt_t  forwarded packet of granted requester.
REQ-013 SHALL have port mem_rsp_vld  input  1  memory response valid; responses return in request order.
REQ-014 SHALL have port mem_rsp_rdy  output  1  arbiter accepts memory response.
REQ-015 SHALL have port mem_rsp  input  mem_pkt_t  memory response packet.
REQ-016 SHALL have port err_unexp_rsp  output  1  sticky: response arrived with no outstanding request.

Function
REQ-017 SHALL implement FSM states ARB, HOLD0, HOLD1 plus a round-robin pointer rr (0 or 1) and an ID FIFO of depth MAX_OUTST.
REQ-018 In ARB: single valid requester is granted; both valid -> grant requester rr; none valid -> no grant, mem_req_vld=0.
REQ-019 In HOLDg: grant is fixed to g regardless of the other requester.
REQ-020 Request path combinational, zero latency: mem_req=mg_req, mem_req_vld=mg_req_vld && !full, mg_req_rdy=mem_req_rdy && !full, non-granted req_rdy=0.
REQ-021 Handshake (mem_req_vld && mem_req_rdy): push g into FIFO, rr<=~g, next state ARB.
REQ-022 Granted, valid, not accepted (memory stall or FIFO full): next state HOLDg.
REQ-023 HOLDg with mg_req_vld low (protocol violation): return to ARB next cycle, rr unchanged, nothing pushed.
REQ-024 Response routing: head ID h; mh_rsp_vld=mem_rsp_vld && !empty; other rsp_vld=0; m0_rsp=m1_rsp=mem_rsp; mem_rsp_rdy = empty ? 1 : mh_rsp_rdy.
REQ-025 Pop FIFO on mem_rsp_vld && mem_rsp_rdy && !empty; simultaneous push and pop leaves count unchanged.
REQ-026 full = registered count==MAX_OUTST; pop in the same cycle does not unblock push until next cycle.
REQ-027 FIFO pointers wrap modulo MAX_OUTST; count width $clog2(MAX_OUTST)+1.
REQ-028 mem_rsp_vld while empty: response dropped (mem_rsp_rdy=1), err_unexp_rsp set and held until reset.

Reset
REQ-029 rst_n low SHALL asynchronously force: state ARB, rr=0, FIFO empty (count 0, pointers 0), err_unexp_rsp=0; hence mem_req_vld=0, mN_req_rdy=0, mN_rsp_vld=0.
REQ-030 Reset mid-transaction SHALL discard all outstanding IDs; no response is routed after reset until a new request is accepted.

Structure
REQ-031 mem_pkt_t and mem op enum SHALL come from memory_types_pkg; arbiter adds only a 1-bit requester-ID type there (req_id_t).
REQ-032 ID FIFO SHALL be a sub-module arb_id_fifo (parameterised depth/width, push/pop/full/empty/head).
REQ-033 FSM state enum SHALL be local to mem_port_arbiter.

Verification
REQ-034 Both valid every cycle, mem_req_rdy=1, immediate responses -> grants alternate 0,1,0,1; responses reach issuing requester.
REQ-035 m0 valid addr 0x100, mem_req_rdy low 3 cycles, m1 valid meanwhile -> mem_req stays 0x100 for 4 cycles, m1 granted next.
REQ-036 MAX_OUTST=4, 4 accepted, no responses -> mem_req_vld=0; one response -> push resumes the cycle after pop.
REQ-037 Issue m0,m1,m0; respond in order with m1_rsp_rdy low 2 cycles -> mem_rsp_rdy low 2 cycles, order preserved.
REQ-038 mem_rsp_vld with FIFO empty -> err_unexp_rsp=1 next cycle, stays 1; rst_n pulse clears it.
REQ-039 rst_n asserted with 2 outstanding mid-stall -> all outputs 0 immediately, FIFO empty after release.
